// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch path: FSM state encoding and the default
// datapath widths shared with the program counter and decoder.
package fetch_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  // Fetch FSM state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] VALID = 2'd2;
  localparam logic [1:0] ADV   = 2'd3;

endpackage

// File: rtl/program_mem.sv
// Program store: DEPTH x WIDTH RAM with synchronous write and synchronous
// (registered) read. Contents are never reset.
module program_mem
  import fetch_pkg::*;
#(
  parameter int WIDTH  = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port and registered read port; the read sees the pre-write contents
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/program_fetch_unit.sv
// Program fetch unit: holds the program store, fetches mem[ADDR] into the
// instruction register, hands it to the decoder with a valid/ready handshake
// and then pulses PC_ADV to step the program counter.
// Optional feature macro: PARITY_CHECK_EN (stores an even-parity bit per word
// and raises a sticky PARITY_ERR on a mismatching fetch).
module program_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              PRGM,
  input  logic              WE,
  input  logic [DATA_W-1:0] PRGM_DATA,
  input  logic              RUN,
  output logic [DATA_W-1:0] IR,
  output logic              IR_VALID,
  input  logic              IR_READY,
  output logic              PC_ADV,
  output logic              BUSY,
  output logic              PARITY_ERR
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef PARITY_CHECK_EN
  localparam int MEM_W = DATA_W + 1;

  // Even parity over one instruction word
  function automatic logic calc_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;

  logic              mem_we_s;
  logic [MEM_W-1:0]  mem_wdata_s;
  logic [MEM_W-1:0]  mem_rdata_s;
  logic [ADDR_W-1:0] mem_raddr_s;

  // Writes only in programming mode; reset blocks every write
  assign mem_we_s = PRGM & WE & ~RESET;

`ifdef PARITY_CHECK_EN
  assign mem_wdata_s = {calc_parity(PRGM_DATA), PRGM_DATA};
`else
  assign mem_wdata_s = PRGM_DATA;
`endif

  // In IDLE the read is issued on the incoming ADDR so the word is ready by
  // the end of READ; afterwards the latched address keeps the read stable.
  assign mem_raddr_s = (state_q == IDLE) ? ADDR : addr_q;

  program_mem #(
    .WIDTH  (MEM_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (CLK),
    .we    (mem_we_s),
    .waddr (ADDR),
    .wdata (mem_wdata_s),
    .raddr (mem_raddr_s),
    .rdata (mem_rdata_s)
  );

  // Next-state logic: programming mode forces IDLE from any state
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    if (PRGM) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (RUN) begin
            state_d = READ;
            addr_d  = ADDR;
          end else begin
            state_d = IDLE;
          end
        end
        READ: begin
          ir_d    = mem_rdata_s[DATA_W-1:0];
          state_d = VALID;
        end
        VALID: begin
          if (IR_READY) begin
            state_d = ADV;
          end else begin
            state_d = VALID;
          end
        end
        ADV: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, latched fetch address and instruction register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      ir_q    <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
    end
  end

`ifdef PARITY_CHECK_EN
  logic parity_err_q;
  logic parity_fault_s;

  // A fault is only judged on the READ->VALID load of the IR
  assign parity_fault_s = (state_q == READ) & ~PRGM & (^mem_rdata_s);

  // Sticky parity error, cleared only by reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      parity_err_q <= 1'b0;
    end else if (parity_fault_s) begin
      parity_err_q <= 1'b1;
    end else begin
      parity_err_q <= parity_err_q;
    end
  end

  assign PARITY_ERR = parity_err_q;
`else
  assign PARITY_ERR = 1'b0;
`endif

  assign IR       = ir_q;
  assign IR_VALID = (state_q == VALID);
  assign PC_ADV   = (state_q == ADV);
  assign BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_program_fetch_unit.sv
// Self-checking bench for program_fetch_unit: a table of per-cycle vectors
// followed by hand-written multi-cycle sequences (PC model run, stall,
// PRGM abort, reset mid-VALID, optional parity fault).
module tb_program_fetch_unit;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] ADDR;
  logic       PRGM;
  logic       WE;
  logic [7:0] PRGM_DATA;
  logic       RUN;
  logic [7:0] IR;
  logic       IR_VALID;
  logic       IR_READY;
  logic       PC_ADV;
  logic       BUSY;
  logic       PARITY_ERR;

  int errors = 0;
  int checks = 0;

  program_fetch_unit dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ADDR       (ADDR),
    .PRGM       (PRGM),
    .WE         (WE),
    .PRGM_DATA  (PRGM_DATA),
    .RUN        (RUN),
    .IR         (IR),
    .IR_VALID   (IR_VALID),
    .IR_READY   (IR_READY),
    .PC_ADV     (PC_ADV),
    .BUSY       (BUSY),
    .PARITY_ERR (PARITY_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic       prgm;
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
    logic       run;
    logic       ready;
    logic [7:0] exp_ir;
    logic       exp_valid;
    logic       exp_adv;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk_outs(input string nm, input logic [7:0] ir, input logic v,
                          input logic adv, input logic busy);
    chk({nm, ".IR"}, {24'd0, IR}, {24'd0, ir});
    chk({nm, ".IR_VALID"}, {31'd0, IR_VALID}, {31'd0, v});
    chk({nm, ".PC_ADV"}, {31'd0, PC_ADV}, {31'd0, adv});
    chk({nm, ".BUSY"}, {31'd0, BUSY}, {31'd0, busy});
  endtask

  // Watchdog: the run must never hang
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_words [4];
    int         pc;
    int         n_words;
    int         last_adv;
    int         n_adv;

    exp_words[0] = 8'hA1; exp_words[1] = 8'hB2;
    exp_words[2] = 8'hC3; exp_words[3] = 8'hD4;

    //          name        prgm  we    addr   data   run   ready ir     v     adv   busy
    vecs[0]  = '{"wr0",     1'b1, 1'b1, 4'd0, 8'hA1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"wr1",     1'b1, 1'b1, 4'd1, 8'hB2, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{"wr2",     1'b1, 1'b1, 4'd2, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{"wr3",     1'b1, 1'b1, 4'd3, 8'hD4, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{"we_noprg",1'b0, 1'b1, 4'd2, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{"go_read", 1'b0, 1'b0, 4'd2, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{"valid",   1'b0, 1'b0, 4'd2, 8'h00, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{"hold",    1'b0, 1'b0, 4'd2, 8'h00, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{"accept",  1'b0, 1'b0, 4'd2, 8'h00, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{"to_idle", 1'b0, 1'b0, 4'd3, 8'h00, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{"idle",    1'b0, 1'b0, 4'd3, 8'h00, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{"prgm_id", 1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0};

    // Reset for two cycles
    RESET = 1'b1; ADDR = 4'd0; PRGM = 1'b0; WE = 1'b0; PRGM_DATA = 8'h00;
    RUN = 1'b0; IR_READY = 1'b0;
    tick();
    tick();
    chk_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset.PARITY_ERR", {31'd0, PARITY_ERR}, 32'd0);
    RESET = 1'b0;

    // Table-driven per-cycle vectors
    for (int i = 0; i < 12; i++) begin
      PRGM = vecs[i].prgm; WE = vecs[i].we; ADDR = vecs[i].addr;
      PRGM_DATA = vecs[i].data; RUN = vecs[i].run; IR_READY = vecs[i].ready;
      tick();
      chk_outs(vecs[i].name, vecs[i].exp_ir, vecs[i].exp_valid, vecs[i].exp_adv, vecs[i].exp_busy);
      chk({vecs[i].name, ".PARITY_ERR"}, {31'd0, PARITY_ERR}, 32'd0);
    end

    // Sequence A: PC model attached, IR_READY tied high
    PRGM = 1'b0; WE = 1'b0; pc = 0; ADDR = 4'd0; RUN = 1'b1; IR_READY = 1'b1;
    n_words = 0; n_adv = 0; last_adv = -1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      tick();
      if (IR_VALID) begin
        if (n_words < 4) begin
          chk($sformatf("run.word%0d", n_words), {24'd0, IR}, {24'd0, exp_words[n_words]});
        end
        n_words++;
      end
      if (PC_ADV) begin
        if (last_adv >= 0) begin
          chk($sformatf("run.adv_spacing%0d", n_adv), cyc - last_adv, 32'd4);
        end
        last_adv = cyc;
        n_adv++;
        pc = (pc + 1) % 16;
        ADDR = pc[3:0];
        if (pc == 4) RUN = 1'b0;
      end
    end
    chk("run.words", n_words, 32'd4);
    chk("run.advs", n_adv, 32'd4);
    chk("run.end_busy", {31'd0, BUSY}, 32'd0);

    // Sequence B: decoder stalls 5 cycles in VALID; RUN dropped mid-fetch
    ADDR = 4'd1; RUN = 1'b1; IR_READY = 1'b0;
    tick();
    chk_outs("stall.read", 8'hD4, 1'b0, 1'b0, 1'b1);
    RUN = 1'b0;
    tick();
    chk_outs("stall.valid", 8'hB2, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_outs($sformatf("stall.hold%0d", i), 8'hB2, 1'b1, 1'b0, 1'b1);
    end
    IR_READY = 1'b1;
    tick();
    chk_outs("stall.adv", 8'hB2, 1'b0, 1'b1, 1'b1);
    tick();
    chk_outs("stall.idle", 8'hB2, 1'b0, 1'b0, 1'b0);
    tick();
    chk_outs("stall.stay_idle", 8'hB2, 1'b0, 1'b0, 1'b0);

    // Sequence C: PRGM asserted in READ aborts the fetch
    ADDR = 4'd3; RUN = 1'b1; IR_READY = 1'b1;
    tick();
    chk_outs("abort.read", 8'hB2, 1'b0, 1'b0, 1'b1);
    PRGM = 1'b1; WE = 1'b0;
    tick();
    chk_outs("abort.idle", 8'hB2, 1'b0, 1'b0, 1'b0);
    PRGM = 1'b0; RUN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_outs($sformatf("abort.quiet%0d", i), 8'hB2, 1'b0, 1'b0, 1'b0);
    end

    // Sequence D: reset mid-VALID, memory preserved
    ADDR = 4'd0; RUN = 1'b1; IR_READY = 1'b0;
    tick();
    tick();
    chk_outs("rst.valid", 8'hA1, 1'b1, 1'b0, 1'b1);
    RESET = 1'b1;
    tick();
    chk_outs("rst.edge1", 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    chk_outs("rst.edge2", 8'h00, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0; ADDR = 4'd3; IR_READY = 1'b1;
    tick();
    tick();
    chk_outs("rst.mem_kept", 8'hD4, 1'b1, 1'b0, 1'b1);
    RUN = 1'b0;
    tick();
    tick();
    chk("rst.back_idle", {31'd0, BUSY}, 32'd0);

`ifdef PARITY_CHECK_EN
    // Sequence E: corrupt a stored data bit, fetch it, error is sticky
    chk("par.clean", {31'd0, PARITY_ERR}, 32'd0);
    dut.u_mem.mem_q[1] = dut.u_mem.mem_q[1] ^ 9'h001;
    ADDR = 4'd1; RUN = 1'b1; IR_READY = 1'b1;
    tick();
    chk("par.read", {31'd0, PARITY_ERR}, 32'd0);
    RUN = 1'b0;
    tick();
    chk("par.valid", {31'd0, PARITY_ERR}, 32'd1);
    chk("par.ir_loaded", {24'd0, IR}, 32'h0000_00B3);
    chk("par.handshake", {31'd0, IR_VALID}, 32'd1);
    tick();
    tick();
    tick();
    chk("par.sticky", {31'd0, PARITY_ERR}, 32'd1);
    RESET = 1'b1;
    tick();
    chk("par.reset", {31'd0, PARITY_ERR}, 32'd0);
    RESET = 1'b0;
`else
    chk("par.tied0", {31'd0, PARITY_ERR}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
